// File: rtl/load_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : load_unit_pkg
//  Brief   : Load func3 encodings, FSM state codes and decode helpers.
//  Rev     : 1.0  initial release
// ============================================================================
package load_unit_pkg;

    localparam logic [2:0] c_F3_LB  = 3'b000;
    localparam logic [2:0] c_F3_LH  = 3'b001;
    localparam logic [2:0] c_F3_LW  = 3'b010;
    localparam logic [2:0] c_F3_LBU = 3'b100;
    localparam logic [2:0] c_F3_LHU = 3'b101;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_WAIT = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    function automatic logic f3_is_load(input logic [2:0] f3);
        case (f3)
            c_F3_LB, c_F3_LH, c_F3_LW, c_F3_LBU, c_F3_LHU: f3_is_load = 1'b1;
            default:                                      f3_is_load = 1'b0;
        endcase
    endfunction

    // Byte loads can never be misaligned; non-load codes are not flagged here.
    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            c_F3_LW:           f3_misaligned = (off != 2'b00);
            c_F3_LH, c_F3_LHU: f3_misaligned = off[0];
            default:           f3_misaligned = 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_unit_extract.sv
`default_nettype none
// ============================================================================
//  Module  : load_extract
//  Brief   : Selects the addressed byte/half/word lane and sign/zero extends.
//  Rev     : 1.0  initial release
// ============================================================================
module load_extract
    import load_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [2:0]            i_func3,
    input  logic [1:0]            i_byte_off,
    input  logic [DATA_WIDTH-1:0] i_word,
    output logic [DATA_WIDTH-1:0] o_result
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte   = i_word[{i_byte_off, 3'b000} +: 8];
        w_half   = i_byte_off[1] ? i_word[31:16] : i_word[15:0];
        o_result = '0;
        case (i_func3)
            c_F3_LB:  o_result = {{(DATA_WIDTH-8){w_byte[7]}}, w_byte};
            c_F3_LH:  o_result = {{(DATA_WIDTH-16){w_half[15]}}, w_half};
            c_F3_LW:  o_result = i_word;
            c_F3_LBU: o_result = {{(DATA_WIDTH-8){1'b0}}, w_byte};
            c_F3_LHU: o_result = {{(DATA_WIDTH-16){1'b0}}, w_half};
            default:  o_result = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_unit.sv
`default_nettype none
// ============================================================================
//  Module  : load_unit
//  Brief   : RV32I memory-stage load controller: issues bram read, stalls PC,
//            extends the result and pulses load_valid for write-back.
//  Rev     : 1.0  initial release
// ============================================================================
module load_unit
    import load_unit_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 10,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_req,
    input  logic [2:0]            func3,
    input  logic [DATA_WIDTH-1:0] addr,
    output logic [ADDR_WIDTH-1:0] mem_r_addr,
    output logic                  mem_r_enb,
    input  logic [DATA_WIDTH-1:0] mem_r_dat,
    output logic [DATA_WIDTH-1:0] load_data,
    output logic                  load_valid,
    output logic                  stall,
    output logic                  misaligned,
    output logic                  illegal
);

    localparam int CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    logic [1:0]            r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [2:0]            r_func3;
    logic [1:0]            r_off;
    logic [DATA_WIDTH-1:0] r_load_data;

    logic                  w_req_ok;
    logic                  w_mis;
    logic                  w_legal;
    logic                  w_accept;
    logic [DATA_WIDTH-1:0] w_ext;
    logic                  w_unused_addr;

    // rst gates the request so stall/enable fall the instant reset asserts.
    assign w_req_ok = load_req & (r_state == c_ST_IDLE) & ~rst;
    assign w_mis    = f3_misaligned(func3, addr[1:0]);
    assign w_legal  = f3_is_load(func3);
    assign w_accept = w_req_ok & w_legal & ~w_mis;

    assign mem_r_enb  = w_accept;
    assign mem_r_addr = w_accept ? {addr[ADDR_WIDTH-1:2], 2'b00} : '0;
    assign stall      = w_accept | (r_state == c_ST_WAIT);
    assign load_valid = (r_state == c_ST_DONE);
    assign misaligned = w_req_ok & w_mis;
    assign illegal    = w_req_ok & ~w_legal & ~w_mis;
    assign load_data  = r_load_data;

    assign w_unused_addr = ^addr[DATA_WIDTH-1:ADDR_WIDTH];

    load_extract #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_extract (
        .i_func3    (r_func3),
        .i_byte_off (r_off),
        .i_word     (mem_r_dat),
        .o_result   (w_ext)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_cnt       <= '0;
            r_func3     <= '0;
            r_off       <= '0;
            r_load_data <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        r_func3 <= func3;
                        r_off   <= addr[1:0];
                        r_cnt   <= CNT_W'(READ_LATENCY - 1);
                        r_state <= c_ST_WAIT;
                    end
                end
                c_ST_WAIT: begin
                    if (r_cnt == '0) begin
                        r_load_data <= w_ext;
                        r_state     <= c_ST_DONE;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                c_ST_DONE: r_state <= c_ST_IDLE;
                default:   r_state <= c_ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_load_unit.sv
`default_nettype none
// ============================================================================
//  Module  : tb_load_unit
//  Brief   : Directed self-checking bench for load_unit (latency 1 and 2).
//  Rev     : 1.0  initial release
// ============================================================================
module tb_load_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_req = 1'b0;
    logic        req2 = 1'b0;
    logic [2:0]  func3 = 3'b000;
    logic [31:0] addr = '0;

    logic [9:0]  mem_r_addr, mem_r_addr2;
    logic        mem_r_enb, mem_r_enb2;
    logic [31:0] mem_r_dat = '0, mem_r_dat2 = '0, r_pipe2 = '0;
    logic [31:0] load_data, load_data2;
    logic        load_valid, load_valid2, stall, stall2;
    logic        misaligned, misaligned2, illegal, illegal2;

    logic [31:0] mem [0:255];
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    load_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .READ_LATENCY(1)) u_dut (
        .clk(clk), .rst(rst), .load_req(load_req), .func3(func3), .addr(addr),
        .mem_r_addr(mem_r_addr), .mem_r_enb(mem_r_enb), .mem_r_dat(mem_r_dat),
        .load_data(load_data), .load_valid(load_valid), .stall(stall),
        .misaligned(misaligned), .illegal(illegal)
    );

    load_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .READ_LATENCY(2)) u_dut2 (
        .clk(clk), .rst(rst), .load_req(req2), .func3(func3), .addr(addr),
        .mem_r_addr(mem_r_addr2), .mem_r_enb(mem_r_enb2), .mem_r_dat(mem_r_dat2),
        .load_data(load_data2), .load_valid(load_valid2), .stall(stall2),
        .misaligned(misaligned2), .illegal(illegal2)
    );

    // Registered-read bram models: one and two cycles of latency.
    always @(posedge clk) begin
        if (mem_r_enb)  mem_r_dat <= mem[mem_r_addr[9:2]];
        if (mem_r_enb2) r_pipe2   <= mem[mem_r_addr2[9:2]];
        mem_r_dat2 <= r_pipe2;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Full load through the latency-1 unit: accept at T, valid at T+2.
    task automatic do_load(input string tag, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] exp);
        cyc();
        load_req = 1'b1; func3 = f3; addr = a;
        #1;
        chk({tag, ".enb"},   32'(mem_r_enb), 32'd1);
        chk({tag, ".raddr"}, 32'(mem_r_addr), {22'd0, a[9:2], 2'b00});
        chk({tag, ".stallT"}, 32'(stall), 32'd1);
        cyc();
        load_req = 1'b0;
        #1;
        chk({tag, ".stallT1"}, 32'(stall), 32'd1);
        chk({tag, ".vldT1"},   32'(load_valid), 32'd0);
        cyc();
        #1;
        chk({tag, ".vldT2"},   32'(load_valid), 32'd1);
        chk({tag, ".stallT2"}, 32'(stall), 32'd0);
        chk({tag, ".data"},    load_data, exp);
    endtask

    // Error request held for one cycle; nothing issued, nothing completes.
    task automatic do_err(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic exp_mis, input logic exp_ill);
        cyc();
        load_req = 1'b1; func3 = f3; addr = a;
        #1;
        chk({tag, ".mis"},   32'(misaligned), 32'(exp_mis));
        chk({tag, ".ill"},   32'(illegal), 32'(exp_ill));
        chk({tag, ".enb"},   32'(mem_r_enb), 32'd0);
        chk({tag, ".stall"}, 32'(stall), 32'd0);
        cyc();
        load_req = 1'b0;
        #1;
        chk({tag, ".pulse"}, 32'(misaligned | illegal), 32'd0);
        cyc();
        #1;
        chk({tag, ".novld"}, 32'(load_valid), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hDEAD_0000 | i;
        mem[0] = 32'h1122_3344;
        mem[3] = 32'h0000_0008;
        mem[1] = 32'h0000_80FF;

        #3;
        chk("rst.state_vld", 32'(load_valid), 32'd0);
        chk("rst.stall",     32'(stall), 32'd0);
        chk("rst.data",      load_data, 32'd0);
        chk("rst.enb",       32'(mem_r_enb), 32'd0);
        cyc();
        rst = 1'b0;

        do_load("lw_c",   3'b010, 32'h0000_000C, 32'h0000_0008);
        do_load("lb_5",   3'b000, 32'h0000_0005, 32'hFFFF_FF80);
        do_load("lbu_5",  3'b100, 32'h0000_0005, 32'h0000_0080);
        do_load("lb_4",   3'b000, 32'h0000_0004, 32'hFFFF_FFFF);

        mem[1] = 32'h8001_0000;
        do_load("lh_6",   3'b001, 32'h0000_0006, 32'hFFFF_8001);
        do_load("lhu_6",  3'b101, 32'h0000_0006, 32'h0000_8001);
        do_load("lh_4",   3'b001, 32'h0000_0004, 32'h0000_0000);
        do_load("lw_wrap", 3'b010, 32'h0000_040C, 32'h0000_0008);

        do_err("mis_lw6",  3'b010, 32'h0000_0006, 1'b1, 1'b0);
        do_err("mis_lhu1", 3'b101, 32'h0000_0001, 1'b1, 1'b0);
        do_err("ill_011",  3'b011, 32'h0000_0000, 1'b0, 1'b1);
        do_err("ill_111",  3'b111, 32'h0000_0004, 1'b0, 1'b1);
        chk("hold.data", load_data, 32'h0000_0008);

        // Reset while waiting on the bram.
        cyc();
        load_req = 1'b1; func3 = 3'b010; addr = 32'h0000_0000;
        cyc();
        load_req = 1'b0;
        #1;
        chk("rstw.stall_pre", 32'(stall), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("rstw.stall", 32'(stall), 32'd0);
        chk("rstw.enb",   32'(mem_r_enb), 32'd0);
        chk("rstw.vld",   32'(load_valid), 32'd0);
        cyc();
        rst = 1'b0;
        #1;
        chk("rstw.vld2",  32'(load_valid), 32'd0);
        do_load("rstw.lw", 3'b010, 32'h0000_000C, 32'h0000_0008);

        // Back-to-back: second request one cycle after DONE.
        do_load("b2b_0", 3'b010, 32'h0000_0000, 32'h1122_3344);
        do_load("b2b_4", 3'b010, 32'h0000_0004, 32'h8001_0000);

        // Latency-2 unit: valid at T+3.
        cyc();
        req2 = 1'b1; func3 = 3'b010; addr = 32'h0000_0000;
        #1;
        chk("rl2.enb", 32'(mem_r_enb2), 32'd1);
        cyc();
        req2 = 1'b0;
        #1;
        chk("rl2.stallT1", 32'(stall2), 32'd1);
        cyc();
        #1;
        chk("rl2.stallT2", 32'(stall2), 32'd1);
        chk("rl2.vldT2",   32'(load_valid2), 32'd0);
        cyc();
        #1;
        chk("rl2.vldT3",   32'(load_valid2), 32'd1);
        chk("rl2.stallT3", 32'(stall2), 32'd0);
        chk("rl2.data",    load_data2, 32'h1122_3344);
        chk("rl2.flags",   32'(misaligned2 | illegal2), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
